gol_grid_streamer: RTL and testbench

Downstream consumer of the Game of Life cell array. On a snapshot request it captures the flattened grid state into a shadow register. It then streams the snapshot out row by row over a valid/ready interface to a display or host link. It also reports the live-cell population per snapshot and keeps a running generation counter.

---
 rtl/gol_pkg.sv | 25 ++
 rtl/gol_row_popcount.sv | 17 +
 rtl/gol_grid_streamer.sv | 147 ++++++++++++++
 tb/tb_gol_grid_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared Game of Life definitions: grid bit ordering, derived widths
// and the streamer state encoding.
package gol_pkg;

    localparam int GRID_SIZE_DEF = 3;

    typedef enum logic {
        IDLE,
        STREAM
    } gol_stream_state_e;

    // Cell (r, c) lives at bit r*n + c of the flattened grid.
    function automatic int cell_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    function automatic int row_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pop_w(input int n);
        return $clog2(n * n + 1);
    endfunction

endpackage

// File: rtl/gol_row_popcount.sv
// Combinational live-cell count of a single grid row.
module gol_row_popcount #(
    parameter int WIDTH = 3,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/gol_grid_streamer.sv
// Snapshots the cell array and streams it out row by row over
// valid/ready, reporting population and a generation counter.
module gol_grid_streamer
    import gol_pkg::*;
#(
    parameter int GRID_SIZE = GRID_SIZE_DEF,
    parameter int GEN_W = 16,
    localparam int ROW_W = row_w(GRID_SIZE),
    localparam int POP_W = pop_w(GRID_SIZE),
    localparam int CELLS = GRID_SIZE * GRID_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CELLS-1:0]     grid_i,
    input  logic                 snap_i,
    output logic                 snap_ready_o,
    output logic                 row_valid_o,
    input  logic                 row_ready_i,
    output logic [GRID_SIZE-1:0] row_data_o,
    output logic [ROW_W-1:0]     row_idx_o,
    output logic                 row_last_o,
    output logic [POP_W-1:0]     pop_o,
    output logic                 pop_valid_o,
    output logic [GEN_W-1:0]     gen_cnt_o,
    output logic                 overrun_o
);

    localparam int PC_W = $clog2(GRID_SIZE + 1);

    gol_stream_state_e state_q;
    gol_stream_state_e state_d;

    logic [CELLS-1:0] shadow_q;
    logic [ROW_W-1:0] ptr_q;
    logic [POP_W-1:0] acc_q;
    logic [POP_W-1:0] pop_q;
    logic             pop_valid_q;
    logic [GEN_W-1:0] gen_q;
    logic             overrun_q;

    logic [GRID_SIZE-1:0] row;
    logic [PC_W-1:0]      row_pop;
    logic                 handshake;
    logic                 accept;
    logic                 frame_done;

    assign row = shadow_q[cell_idx(int'(ptr_q), 0, GRID_SIZE) +: GRID_SIZE];

    gol_row_popcount #(
        .WIDTH(GRID_SIZE)
    ) u_row_popcount (
        .bits (row),
        .count(row_pop)
    );

    assign row_data_o = row;
    assign row_idx_o  = ptr_q;
    assign row_last_o = (ptr_q == ROW_W'(GRID_SIZE - 1));

    assign handshake  = row_valid_o & row_ready_i;
    assign frame_done = handshake & row_last_o;
    assign accept     = snap_i & snap_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = STREAM;
            end
            STREAM: begin
                if (frame_done && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready also rises on the final beat so a new frame follows with no bubble.
    always_comb begin
        row_valid_o  = 1'b0;
        snap_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                snap_ready_o = 1'b1;
            end
            STREAM: begin
                row_valid_o  = 1'b1;
                snap_ready_o = row_ready_i & row_last_o;
            end
            default: begin
                row_valid_o  = 1'b0;
                snap_ready_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            ptr_q    <= '0;
            acc_q    <= '0;
            gen_q    <= '0;
        end else if (accept) begin
            shadow_q <= grid_i;
            ptr_q    <= '0;
            acc_q    <= '0;
            gen_q    <= gen_q + GEN_W'(1);
        end else if (handshake && !row_last_o) begin
            ptr_q <= ptr_q + ROW_W'(1);
            acc_q <= acc_q + POP_W'(row_pop);
        end
    end

    // The final row is folded in directly, so pop_o never waits on acc_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_q       <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= frame_done;
            if (frame_done) begin
                pop_q <= acc_q + POP_W'(row_pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (snap_i && !snap_ready_o) begin
            overrun_q <= 1'b1;
        end
    end

    assign pop_o       = pop_q;
    assign pop_valid_o = pop_valid_q;
    assign gen_cnt_o   = gen_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_gol_grid_streamer.sv
// Self-checking bench for gol_grid_streamer: vector table, directed
// corner sequences and a randomized run against a frame-level model.
module tb_gol_grid_streamer;

    localparam int N  = 3;
    localparam int GW = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [8:0]   grid;
    logic         snap;
    logic         ready;
    logic         snap_ready;
    logic         row_valid;
    logic [2:0]   row_data;
    logic [1:0]   row_idx;
    logic         row_last;
    logic [3:0]   pop;
    logic         pop_valid;
    logic [GW-1:0] gen_cnt;
    logic         overrun;

    int total = 0;
    int bad   = 0;

    gol_grid_streamer #(
        .GRID_SIZE(N),
        .GEN_W(GW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .grid_i      (grid),
        .snap_i      (snap),
        .snap_ready_o(snap_ready),
        .row_valid_o (row_valid),
        .row_ready_i (ready),
        .row_data_o  (row_data),
        .row_idx_o   (row_idx),
        .row_last_o  (row_last),
        .pop_o       (pop),
        .pop_valid_o (pop_valid),
        .gen_cnt_o   (gen_cnt),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [8:0] g);
        @(negedge clk);
        snap  = s;
        ready = r;
        grid  = g;
        #1;
    endtask

    // Frame-level reference: a captured grid, the row being offered,
    // and counters derived from whole-frame facts.
    bit       m_busy;
    int       m_row;
    bit [8:0] m_frame;
    int       m_gen;
    int       m_pop;
    bit       m_popv;
    bit       m_ovr;

    task automatic model_reset();
        m_busy = 0; m_row = 0; m_frame = '0;
        m_gen = 0; m_pop = 0; m_popv = 0; m_ovr = 0;
    endtask

    task automatic model_check(input string tag);
        bit last;
        last = (m_row == N - 1);
        chk({tag, " valid"}, row_valid, m_busy);
        if (m_busy) begin
            chk({tag, " idx"}, row_idx, m_row);
            chk({tag, " data"}, row_data, (m_frame >> (m_row * N)) & 9'h7);
            chk({tag, " last"}, row_last, last);
        end
        chk({tag, " sready"}, snap_ready, !m_busy || (ready && last));
        chk({tag, " popv"}, pop_valid, m_popv);
        chk({tag, " pop"}, pop, m_pop);
        chk({tag, " gen"}, gen_cnt, m_gen);
        chk({tag, " ovr"}, overrun, m_ovr);
    endtask

    task automatic model_step();
        bit done;
        bit sr;
        done = m_busy && ready && (m_row == N - 1);
        sr   = !m_busy || done;
        m_popv = done;
        if (done) m_pop = $countones(m_frame);
        if (snap && !sr) m_ovr = 1;
        if (snap && sr) begin
            m_frame = grid;
            m_row   = 0;
            m_busy  = 1;
            m_gen   = (m_gen + 1) % (1 << GW);
        end else if (done) begin
            m_busy = 0;
        end else if (m_busy && ready) begin
            m_row++;
        end
    endtask

    typedef struct {
        logic       s;
        logic       r;
        logic [8:0] g;
        logic       v;
        int         idx;
        logic [2:0] d;
        logic       l;
        logic       sr;
        logic       pv;
        int         pop;
        int         gen;
        logic       ov;
    } vec_t;

    vec_t tbl[16];
    logic [8:0] wg;

    initial begin
        // blinker, back-to-back 1FF with stalls, then 092 with no bubble
        tbl[0]  = '{1, 1, 9'h038, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 9'h038, 1, 0, 3'b000, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 9'h038, 1, 1, 3'b111, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 9'h038, 1, 2, 3'b000, 1, 1, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 9'h000, 0, 0, 3'b000, 0, 1, 1, 3, 1, 0};
        tbl[5]  = '{1, 0, 9'h1FF, 0, 0, 3'b000, 0, 1, 0, 3, 1, 0};
        tbl[6]  = '{0, 0, 9'h000, 1, 0, 3'b111, 0, 0, 0, 3, 2, 0};
        tbl[7]  = '{0, 0, 9'h000, 1, 0, 3'b111, 0, 0, 0, 3, 2, 0};
        tbl[8]  = '{0, 1, 9'h000, 1, 0, 3'b111, 0, 0, 0, 3, 2, 0};
        tbl[9]  = '{0, 0, 9'h000, 1, 1, 3'b111, 0, 0, 0, 3, 2, 0};
        tbl[10] = '{0, 1, 9'h000, 1, 1, 3'b111, 0, 0, 0, 3, 2, 0};
        tbl[11] = '{1, 1, 9'h092, 1, 2, 3'b111, 1, 1, 0, 3, 2, 0};
        tbl[12] = '{0, 1, 9'h000, 1, 0, 3'b010, 0, 0, 1, 9, 3, 0};
        tbl[13] = '{0, 1, 9'h000, 1, 1, 3'b010, 0, 0, 0, 9, 3, 0};
        tbl[14] = '{0, 1, 9'h000, 1, 2, 3'b010, 1, 1, 0, 9, 3, 0};
        tbl[15] = '{0, 1, 9'h000, 0, 0, 3'b000, 0, 1, 1, 3, 3, 0};

        rst = 1'b1; snap = 1'b0; ready = 1'b0; grid = '0;
        #1;
        chk("rst valid", row_valid, 0);
        chk("rst sready", snap_ready, 1);
        chk("rst gen", gen_cnt, 0);
        chk("rst pop", pop, 0);
        chk("rst popv", pop_valid, 0);
        chk("rst ovr", overrun, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].s, tbl[i].r, tbl[i].g);
            chk({t, " valid"}, row_valid, tbl[i].v);
            if (tbl[i].v) begin
                chk({t, " idx"}, row_idx, tbl[i].idx);
                chk({t, " data"}, row_data, tbl[i].d);
                chk({t, " last"}, row_last, tbl[i].l);
            end
            chk({t, " sready"}, snap_ready, tbl[i].sr);
            chk({t, " popv"}, pop_valid, tbl[i].pv);
            chk({t, " pop"}, pop, tbl[i].pop);
            chk({t, " gen"}, gen_cnt, tbl[i].gen);
            chk({t, " ovr"}, overrun, tbl[i].ov);
        end

        // overrun during beat 1; gen wraps 3 -> 0 on this accept
        drive(1, 1, 9'h1FF);
        drive(0, 1, 9'h000);
        chk("ovr gen wrap", gen_cnt, 0);
        chk("ovr b0 idx", row_idx, 0);
        drive(1, 0, 9'h000);
        chk("ovr b1 sready", snap_ready, 0);
        chk("ovr b1 idx", row_idx, 1);
        drive(0, 1, 9'h000);
        chk("ovr sticky", overrun, 1);
        chk("ovr b1 hold", row_idx, 1);
        chk("ovr b1 data", row_data, 3'b111);
        chk("ovr gen", gen_cnt, 0);
        drive(0, 1, 9'h000);
        chk("ovr b2 idx", row_idx, 2);
        chk("ovr b2 data", row_data, 3'b111);
        drive(0, 0, 9'h000);
        chk("ovr done valid", row_valid, 0);
        chk("ovr popv", pop_valid, 1);
        chk("ovr pop", pop, 9);
        chk("ovr still", overrun, 1);

        // asynchronous reset while beat 1 is on the bus
        drive(1, 1, 9'h038);
        drive(0, 1, 9'h038);
        drive(0, 0, 9'h038);
        chk("mid b1", row_idx, 1);
        rst = 1'b1;
        #1;
        chk("mid rst valid", row_valid, 0);
        chk("mid rst gen", gen_cnt, 0);
        chk("mid rst pop", pop, 0);
        chk("mid rst ovr", overrun, 0);
        chk("mid rst sready", snap_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 9'h000);
            chk($sformatf("post rst popv%0d", i), pop_valid, 0);
            chk($sformatf("post rst valid%0d", i), row_valid, 0);
        end

        // four snapshots: gen 1,2,3,0; grid_i scrambled mid-frame
        for (int k = 1; k <= 4; k++) begin
            wg = 9'($urandom);
            drive(1, 1, wg);
            for (int r = 0; r < N; r++) begin
                drive(0, 1, 9'($urandom));
                chk($sformatf("wrap%0d gen", k), gen_cnt, k % 4);
                chk($sformatf("wrap%0d r%0d", k, r), row_data, (wg >> (r * N)) & 9'h7);
            end
            drive(0, 0, 9'h000);
            chk($sformatf("wrap%0d pop", k), pop, $countones(wg));
        end

        // randomized run against the frame-level model
        @(negedge clk);
        rst = 1'b1;
        snap = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                  9'($urandom));
            model_check($sformatf("rnd%0d", c));
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
